// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_pkg                                                             |
// | Shared constants, counter encodings and entry type for predictors. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package bp_pkg;

    localparam int XLEN       = 32;
    localparam int BP_INDEX_W = 4;
    localparam int BP_TAG_W   = XLEN - BP_INDEX_W - 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [XLEN-1:0]     target;
        logic                jump;
        logic [1:0]          ctr;
    } bp_entry_t;

endpackage
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_sat_counter                                                     |
// | 2-bit saturating counter next-state function (ctr, taken).         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_taken,
    output logic [1:0] o_ctr_next
);

    always_comb begin
        o_ctr_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) o_ctr_next = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr_next = i_ctr - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | branch_predictor                                                   |
// | Fetch-stage BHT (2-bit counters) + direct-mapped BTB, 0-cycle      |
// | lookup. Optional BP_STATS_EN adds lookup/mispredict counters.      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module branch_predictor #(
    parameter int XLEN    = bp_pkg::XLEN,
    parameter int INDEX_W = bp_pkg::BP_INDEX_W,
    parameter int TAG_W   = XLEN - INDEX_W - 2
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_is_jump,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
`endif
);

    import bp_pkg::*;

    localparam int c_ENTRIES = 2 ** INDEX_W;

    logic             r_valid  [c_ENTRIES];
    logic [TAG_W-1:0] r_tag    [c_ENTRIES];
    logic [XLEN-1:0]  r_target [c_ENTRIES];
    logic             r_jump   [c_ENTRIES];
    logic [1:0]       r_ctr    [c_ENTRIES];

    logic [INDEX_W-1:0] w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;
    logic [XLEN-1:0]    w_if_pc_plus4;

    logic [INDEX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic [1:0]         w_ctr_next;

    // Word-offset bits are never used for indexing or tagging.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, if_pc[1:0], upd_pc[1:0], upd_mispredict};

    assign w_if_idx      = if_pc[INDEX_W+1:2];
    assign w_if_tag      = if_pc[XLEN-1:INDEX_W+2];
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_if_pc_plus4 = if_pc + XLEN'(4);

    assign pred_taken  = if_valid && w_if_hit && (r_jump[w_if_idx] || r_ctr[w_if_idx][1]);
    assign pred_target = pred_taken ? r_target[w_if_idx] : w_if_pc_plus4;

    assign w_upd_idx = upd_pc[INDEX_W+1:2];
    assign w_upd_tag = upd_pc[XLEN-1:INDEX_W+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    bp_sat_counter u_sat_counter (
        .i_ctr      (r_ctr[w_upd_idx]),
        .i_taken    (upd_taken),
        .o_ctr_next (w_ctr_next)
    );

    // Valid and counter state carry the reset; payload fields are don't-care until allocated.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= WNT;
            end
        end else if (upd_valid) begin
            if (w_upd_hit) begin
                if (!upd_is_jump) r_ctr[w_upd_idx] <= w_ctr_next;
            end else if (upd_taken) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_ctr[w_upd_idx]   <= upd_is_jump ? ST : WT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (upd_valid) begin
            if (w_upd_hit) begin
                r_jump[w_upd_idx] <= upd_is_jump;
                if (upd_taken) r_target[w_upd_idx] <= upd_target;
            end else if (upd_taken) begin
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target;
                r_jump[w_upd_idx]   <= upd_is_jump;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stat_lookups     <= 32'd0;
            r_stat_mispredicts <= 32'd0;
        end else begin
            if (if_valid)                        r_stat_lookups     <= r_stat_lookups + 32'd1;
            if (upd_valid && upd_mispredict)     r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_branch_predictor                                                |
// | Scoreboard bench: directed lookups/updates with expected results.  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_branch_predictor;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_is_jump = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic        upd_mispredict = 1'b0;
`ifdef BP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_jump    (upd_is_jump),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    logic probe  = 1'b0;

    // Monitor: compares the DUT's lookup result against the queued expectation.
    always @(negedge CLK) begin
        if (probe) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: probe with empty queue");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (pred_taken !== e.taken || pred_target !== e.target) begin
                    errors++;
                    $display("FAIL lookup_%0d: got taken=%0b target=%h, expected taken=%0b target=%h",
                             e.id, pred_taken, pred_target, e.taken, e.target);
                end
            end
        end
    end

    task automatic push_exp(input logic et, input logic [31:0] etgt);
        exp_t e;
        e.taken  = et;
        e.target = etgt;
        e.id     = vec_id;
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic lookup(input logic v, input logic [31:0] pc, input logic et, input logic [31:0] etgt);
        if_valid  = v;
        if_pc     = pc;
        upd_valid = 1'b0;
        push_exp(et, etgt);
        probe = 1'b1;
        @(posedge CLK);
        #1;
        probe    = 1'b0;
        if_valid = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic jmp, input logic tk,
                          input logic [31:0] tgt, input logic mis);
        if_valid       = 1'b0;
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_jump    = jmp;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mis;
        @(posedge CLK);
        #1;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    task automatic upd_lookup(input logic [31:0] pc, input logic jmp, input logic tk,
                              input logic [31:0] tgt, input logic et, input logic [31:0] etgt);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_is_jump    = jmp;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = 1'b0;
        if_valid       = 1'b1;
        if_pc          = pc;
        push_exp(et, etgt);
        probe = 1'b1;
        @(posedge CLK);
        #1;
        probe     = 1'b0;
        if_valid  = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;

        lookup(1'b1, 32'h100, 1'b0, 32'h104);

        // Allocation as weakly-taken branch, then walk the counter.
        update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        lookup(1'b1, 32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(1'b1, 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(1'b1, 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        lookup(1'b1, 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b0, 1'b1, 32'h88, 1'b0);
        lookup(1'b1, 32'h100, 1'b1, 32'h88);
        update(32'h100, 1'b0, 1'b1, 32'h88, 1'b0);
        update(32'h100, 1'b0, 1'b1, 32'h88, 1'b0);
        update(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        lookup(1'b1, 32'h100, 1'b1, 32'h88);
        lookup(1'b0, 32'h100, 1'b0, 32'h104);

        // Tag alias at the same index, and a not-taken miss that must not allocate.
        update(32'h140, 1'b0, 1'b1, 32'hC0, 1'b0);
        lookup(1'b1, 32'h100, 1'b0, 32'h104);
        lookup(1'b1, 32'h140, 1'b1, 32'hC0);
        update(32'h180, 1'b0, 1'b0, 32'h300, 1'b0);
        lookup(1'b1, 32'h140, 1'b1, 32'hC0);
        lookup(1'b1, 32'h180, 1'b0, 32'h184);

        // JAL: same-cycle lookup sees pre-update state.
        upd_lookup(32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
        lookup(1'b1, 32'h200, 1'b1, 32'h400);
        lookup(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Asynchronous reset mid-run.
        RSTn = 1'b0;
        lookup(1'b1, 32'h200, 1'b0, 32'h204);
        lookup(1'b1, 32'h140, 1'b0, 32'h144);
`ifdef BP_STATS_EN
        check32("stat_lookups_reset", stat_lookups, 32'd0);
        check32("stat_mispredicts_reset", stat_mispredicts, 32'd0);
`endif
        RSTn = 1'b1;
        for (int i = 0; i < 5; i++) lookup(1'b1, 32'h140, 1'b0, 32'h144);
        update(32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
        update(32'h300, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef BP_STATS_EN
        check32("stat_lookups_count", stat_lookups, 32'd5);
        check32("stat_mispredicts_count", stat_mispredicts, 32'd2);
`endif
        lookup(1'b1, 32'h300, 1'b0, 32'h304);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge CLK);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
